// File: rtl/ecg_record_ctrl_pkg.sv
// Shared definitions for the ECG record store: FSM encoding, default geometry and
// the 1-based slot-number range check also used by the UI side.
package ecg_record_ctrl_pkg;

    localparam int DEF_NUM_SLOTS  = 4;
    localparam int DEF_SLOT_DEPTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_PLAY_RD  = 2'd2,
        ST_PLAY_OUT = 2'd3
    } rec_state_e;

    // Slot numbers are 1-based; 0 and anything above num_slots are invalid.
    function automatic logic slot_in_range(input logic [2:0] slot, input int num_slots);
        return (slot != 3'd0) && (int'(slot) <= num_slots);
    endfunction

endpackage

// File: rtl/ecg_record_ctrl_slot_alloc.sv
// Combinational slot bookkeeping: lowest free slot (0-based), full flag and
// number of occupied slots.
module ecg_record_ctrl_slot_alloc
    import ecg_record_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic [NUM_SLOTS-1:0] slot_valid,
    output logic [2:0]           free_idx,
    output logic                 full,
    output logic [2:0]           count
);

    // Scanning from the top down lets the lowest free slot win.
    always_comb begin
        free_idx = 3'd0;
        full     = 1'b1;
        count    = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = 3'(i);
                full     = 1'b0;
            end
            count = count + {2'b00, slot_valid[i]};
        end
    end

endmodule

// File: rtl/ecg_record_ctrl.sv
// ECG record store controller: SAVE / DELETE / PLAY sequencing over one
// single-port BRAM holding NUM_SLOTS fixed-size records.
module ecg_record_ctrl
    import ecg_record_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int SLOT_DEPTH = DEF_SLOT_DEPTH,
    parameter int SAMPLE_W   = 12,
    parameter int ADDR_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 save_req,
    input  logic                 del_req,
    input  logic [2:0]           del_slot,
    input  logic                 play_req,
    input  logic [2:0]           play_slot,
    input  logic                 abort,
    input  logic [SAMPLE_W-1:0]  sample_in,
    input  logic                 sample_valid,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [SAMPLE_W-1:0]  mem_wdata,
    input  logic [SAMPLE_W-1:0]  mem_rdata,
    output logic [SAMPLE_W-1:0]  play_data,
    output logic                 play_valid,
    output logic                 play_last,
    input  logic                 play_ready,
    output logic                 busy,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [2:0]           rec_count,
    output logic                 done,
    output logic                 err
);

    localparam int               CNT_W    = $clog2(SLOT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_DEPTH - 1);

    rec_state_e          state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [2:0]          rec_count_q, rec_count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [SAMPLE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [SAMPLE_W-1:0] play_data_q, play_data_d;
    logic                play_valid_q, play_valid_d;
    logic                play_last_q, play_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [2:0]           free_idx;
    logic                 full;
    logic [2:0]           pop_count;
    logic                 play_hit, del_hit;
    logic [NUM_SLOTS-1:0] del_mask, save_mask;

    ecg_record_ctrl_slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
        .slot_valid (slot_valid_q),
        .free_idx   (free_idx),
        .full       (full),
        .count      (pop_count)
    );

    // Slots are SLOT_DEPTH-aligned, so the base address is just the index above cnt.
    function automatic logic [ADDR_W-1:0] rec_addr(input logic [2:0] idx,
                                                   input logic [CNT_W-1:0] c);
        return ADDR_W'({idx, c});
    endfunction

    always_comb begin
        play_hit  = 1'b0;
        del_hit   = 1'b0;
        del_mask  = '0;
        save_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (play_slot == 3'(i + 1) && slot_valid_q[i]) play_hit = 1'b1;
            if (del_slot == 3'(i + 1) && slot_valid_q[i]) begin
                del_hit     = 1'b1;
                del_mask[i] = 1'b1;
            end
            if (slot_q == 3'(i)) save_mask[i] = 1'b1;
        end
        play_hit = play_hit && slot_in_range(play_slot, NUM_SLOTS);
        del_hit  = del_hit && slot_in_range(del_slot, NUM_SLOTS);
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        rd_pend_d    = rd_pend_q;
        slot_valid_d = slot_valid_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        play_data_d  = play_data_q;
        play_valid_d = play_valid_q;
        play_last_d  = play_last_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        // Any command arriving outside IDLE is refused.
        if (state_q != ST_IDLE) err_d = save_req | play_req | del_req;

        case (state_q)
            ST_IDLE: begin
                if (save_req) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        slot_d  = free_idx;
                        cnt_d   = '0;
                        state_d = ST_SAVE;
                    end
                end else if (play_req) begin
                    if (!play_hit) begin
                        err_d = 1'b1;
                    end else begin
                        slot_d     = play_slot - 3'd1;
                        cnt_d      = '0;
                        mem_addr_d = rec_addr(play_slot - 3'd1, '0);
                        rd_pend_d  = 1'b1;
                        state_d    = ST_PLAY_RD;
                    end
                end else if (del_req) begin
                    if (!del_hit) err_d = 1'b1;
                    else          slot_valid_d = slot_valid_q & ~del_mask;
                end
            end
            ST_SAVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = rec_addr(slot_q, cnt_q);
                    mem_wdata_d = sample_in;
                    if (cnt_q == CNT_LAST) begin
                        slot_valid_d = slot_valid_q | save_mask;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY_RD: begin
                // First cycle presents the address; the second sees read data.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                end else begin
                    play_data_d  = mem_rdata;
                    play_valid_d = 1'b1;
                    play_last_d  = (cnt_q == CNT_LAST);
                    state_d      = ST_PLAY_OUT;
                end
            end
            ST_PLAY_OUT: begin
                if (abort) begin
                    play_valid_d = 1'b0;
                    play_last_d  = 1'b0;
                    state_d      = ST_IDLE;
                end else if (play_ready) begin
                    play_valid_d = 1'b0;
                    play_last_d  = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = rec_addr(slot_q, cnt_q + 1'b1);
                        rd_pend_d  = 1'b1;
                        state_d    = ST_PLAY_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d      = (state_d != ST_IDLE);
        rec_count_d = pop_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            cnt_q        <= '0;
            rd_pend_q    <= 1'b0;
            slot_valid_q <= '0;
            rec_count_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            play_data_q  <= '0;
            play_valid_q <= 1'b0;
            play_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            rd_pend_q    <= rd_pend_d;
            slot_valid_q <= slot_valid_d;
            rec_count_q  <= rec_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            play_data_q  <= play_data_d;
            play_valid_q <= play_valid_d;
            play_last_q  <= play_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign play_data  = play_data_q;
    assign play_valid = play_valid_q;
    assign play_last  = play_last_q;
    assign busy       = busy_q;
    assign slot_valid = slot_valid_q;
    assign rec_count  = rec_count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
